// File: rtl/dmux_pkg.sv
// dmux_pkg: shared types and constants for the dmux_stream_n stream demultiplexer.
//   state_t   : packet FSM states (IDLE, BURST, DROP)
//   CNT_W     : width of each per-channel packet counter (DMUX_PKT_CNT_EN builds)
//   MAX_N_OUT : largest supported channel count
package dmux_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DROP  = 2'd2
    } state_t;

    localparam int CNT_W     = 16;
    localparam int MAX_N_OUT = 16;

endpackage

// File: rtl/dmux_out_reg.sv
// dmux_out_reg: one-entry valid/ready output buffer holding payload, last flag and
// the destination channel tag. A load wins over a drain in the same cycle, which is
// what lets a beat be accepted while the previous one leaves.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   load                write a new entry this cycle
//   drain               current entry is taken by its sink this cycle
//   in_data/last/sel    entry contents to write
//   buf_v               entry present
//   buf_data/last/sel   stored entry
module dmux_out_reg
    import dmux_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int SEL_W  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              drain,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    input  logic [SEL_W-1:0]  in_sel,
    output logic              buf_v,
    output logic [DATA_W-1:0] buf_data,
    output logic              buf_last,
    output logic [SEL_W-1:0]  buf_sel
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_v    <= 1'b0;
            buf_data <= '0;
            buf_last <= 1'b0;
            buf_sel  <= '0;
        end else if (load) begin
            buf_v    <= 1'b1;
            buf_data <= in_data;
            buf_last <= in_last;
            buf_sel  <= in_sel;
        end else if (drain) begin
            buf_v    <= 1'b0;
        end
    end

endmodule

// File: rtl/dmux_stream_n.sv
// dmux_stream_n: 1-to-N_OUT valid/ready stream demultiplexer.
// The channel is taken from in_sel on the first beat of a packet and held until the
// in_last beat. Packets aimed at a non-existent channel are swallowed and flagged on
// err_sel. A single registered output entry gives 1-cycle latency at full rate.
// Optional feature macro: DMUX_PKT_CNT_EN adds pkt_cnt, one 16-bit wrapping counter
// per channel counting delivered last beats.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid/in_ready          input handshake
//   in_data/in_last/in_sel     input payload, end-of-packet, destination
//   out_valid[N_OUT]           one-hot-or-zero pending flag per channel
//   out_ready[N_OUT]           per-channel sink ready
//   out_data/out_last          shared payload bus for the flagged channel
//   busy                       inside a routed packet
//   err_sel                    1-cycle pulse on a dropped packet start
//   pkt_cnt (macro only)       N_OUT x 16-bit packet counters
module dmux_stream_n
    import dmux_pkg::*;
#(
    parameter  int N_OUT  = 4,
    parameter  int DATA_W = 8,
    localparam int SEL_W  = $clog2(N_OUT)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    input  logic [SEL_W-1:0]  in_sel,
    output logic [N_OUT-1:0]  out_valid,
    input  logic [N_OUT-1:0]  out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              err_sel
`ifdef DMUX_PKT_CNT_EN
    ,
    output logic [N_OUT*CNT_W-1:0] pkt_cnt
`endif
);

    state_t             state;
    logic [SEL_W-1:0]   cur_sel;
    logic               buf_v;
    logic               buf_last;
    logic [DATA_W-1:0]  buf_data;
    logic [SEL_W-1:0]   buf_sel;
    logic               sel_ok;
    logic               buf_rdy;
    logic               accept;
    logic               load;
    logic [SEL_W-1:0]   ld_sel;

    assign sel_ok = int'(in_sel) < N_OUT;

    // Decode the buffered tag; only the tagged channel's ready can drain it.
    for (genvar k = 0; k < N_OUT; k++) begin : g_ov
        assign out_valid[k] = buf_v && (buf_sel == SEL_W'(k));
    end

    assign buf_rdy  = |(out_valid & out_ready);
    assign in_ready = (state == DROP) || !buf_v || buf_rdy;
    assign accept   = in_valid && in_ready;
    assign load     = accept && ((state == BURST) || (state == IDLE && sel_ok));
    assign ld_sel   = (state == IDLE) ? in_sel : cur_sel;
    assign out_data = buf_data;
    assign out_last = buf_last;

    dmux_out_reg #(
        .DATA_W (DATA_W),
        .SEL_W  (SEL_W)
    ) u_out_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .drain    (buf_rdy),
        .in_data  (in_data),
        .in_last  (in_last),
        .in_sel   (ld_sel),
        .buf_v    (buf_v),
        .buf_data (buf_data),
        .buf_last (buf_last),
        .buf_sel  (buf_sel)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cur_sel <= '0;
            busy    <= 1'b0;
            err_sel <= 1'b0;
        end else begin
            err_sel <= 1'b0;
            if (accept) begin
                case (state)
                    IDLE: begin
                        if (sel_ok) begin
                            cur_sel <= in_sel;
                            if (!in_last) begin
                                state <= BURST;
                                busy  <= 1'b1;
                            end
                        end else begin
                            // single-beat bad packet never enters DROP
                            err_sel <= 1'b1;
                            if (!in_last) state <= DROP;
                        end
                    end
                    BURST: begin
                        if (in_last) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                    DROP: begin
                        if (in_last) state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef DMUX_PKT_CNT_EN
    for (genvar k = 0; k < N_OUT; k++) begin : g_cnt
        logic [CNT_W-1:0] cnt;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                cnt <= '0;
            else if (out_valid[k] && out_ready[k] && buf_last)
                cnt <= cnt + 1'b1;
        end
        assign pkt_cnt[k*CNT_W +: CNT_W] = cnt;
    end
`endif

endmodule
